poly_voice_mixer: RTL and testbench



---
 rtl/poly_voice_mixer.sv | 210 +++++++++++++++++++++
 tb/tb_poly_voice_mixer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/poly_voice_mixer.sv
// N-voice sample combiner: latches one sample per voice, sums the active voices
// serially, then divides by the active count. Optional peak meter: MIX_PEAK_EN.
module poly_voice_mixer #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 9,
  parameter int ACC_W      = SAMPLE_W + $clog2(NUM_VOICES + 1)
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  logic                           start_i,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] sample_i,
  input  logic [NUM_VOICES-1:0]          active_i,
`ifdef MIX_PEAK_EN
  input  logic                           peak_clr_i,
  output logic [SAMPLE_W-1:0]            peak_o,
`endif
  output logic [SAMPLE_W-1:0]            mix_o,
  output logic                           ready_o,
  output logic                           busy_o,
  output logic                           overrun_o
);

  localparam int CNT_W  = $clog2(NUM_VOICES + 1);
  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int STEP_W = $clog2(ACC_W + 1);
  localparam int REM_W  = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DIV   = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e                         state_q, state_d;
  logic [NUM_VOICES*SAMPLE_W-1:0] samp_q, samp_d;
  logic [NUM_VOICES-1:0]          mask_q, mask_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [REM_W-1:0]               rem_q, rem_d;
  logic [STEP_W-1:0]              step_q, step_d;
  logic [SAMPLE_W-1:0]            mix_q, mix_d;
  logic                           ready_q, ready_d;
  logic                           busy_q, busy_d;
  logic                           overrun_q, overrun_d;

  logic [SAMPLE_W-1:0]            voice_s;
  logic [REM_W-1:0]               rem_shift_s;
  logic [REM_W-1:0]               rem_sub_s;
  logic [REM_W-1:0]               cnt_ext_s;
  logic                           qbit_s;
  logic [ACC_W-1:0]               quo_next_s;

  // One restoring-division step; acc_q doubles as the dividend/quotient shift register.
  always_comb begin
    voice_s     = samp_q[idx_q*SAMPLE_W +: SAMPLE_W];
    cnt_ext_s   = REM_W'(cnt_q);
    rem_shift_s = {rem_q[ACC_W-1:0], acc_q[ACC_W-1]};
    if (rem_shift_s >= cnt_ext_s) begin
      qbit_s    = 1'b1;
      rem_sub_s = rem_shift_s - cnt_ext_s;
    end else begin
      qbit_s    = 1'b0;
      rem_sub_s = rem_shift_s;
    end
    quo_next_s = {acc_q[ACC_W-2:0], qbit_s};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    mask_d    = mask_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    step_d    = step_q;
    mix_d     = mix_q;
    ready_d   = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          samp_d  = sample_i;
          mask_d  = active_i;
          acc_d   = {ACC_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          state_d = S_ACCUM;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        overrun_d = start_i;
        if (mask_q[idx_q]) begin
          acc_d = acc_q + ACC_W'(voice_s);
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          acc_d = acc_q;
        end
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          rem_d   = {REM_W{1'b0}};
          step_d  = {STEP_W{1'b0}};
          state_d = S_DIV;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DIV: begin
        overrun_d = start_i;
        if (cnt_q == CNT_W'(0)) begin
          mix_d   = {SAMPLE_W{1'b0}};
          ready_d = 1'b1;
          state_d = S_OUT;
        end else if (cnt_q == CNT_W'(1)) begin
          mix_d   = acc_q[SAMPLE_W-1:0];
          ready_d = 1'b1;
          state_d = S_OUT;
        end else begin
          rem_d  = rem_sub_s;
          acc_d  = quo_next_s;
          step_d = step_q + STEP_W'(1);
          // The final step's quotient bit goes straight to the output.
          if (step_q == STEP_W'(ACC_W - 1)) begin
            mix_d   = quo_next_s[SAMPLE_W-1:0];
            ready_d = 1'b1;
            state_d = S_OUT;
          end else begin
            state_d = S_DIV;
          end
        end
      end
      S_OUT: begin
        overrun_d = start_i;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      samp_q    <= {(NUM_VOICES*SAMPLE_W){1'b0}};
      mask_q    <= {NUM_VOICES{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      rem_q     <= {REM_W{1'b0}};
      step_q    <= {STEP_W{1'b0}};
      mix_q     <= {SAMPLE_W{1'b0}};
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      mask_q    <= mask_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      step_q    <= step_d;
      mix_q     <= mix_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign mix_o     = mix_q;
  assign ready_o   = ready_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

`ifdef MIX_PEAK_EN
  logic [SAMPLE_W-1:0] peak_q, peak_d;

  // Peak meter updates alongside mix_o; clear wins on a shared edge.
  always_comb begin
    peak_d = peak_q;
    if (peak_clr_i) begin
      peak_d = {SAMPLE_W{1'b0}};
    end else if (ready_d && (mix_d > peak_q)) begin
      peak_d = mix_d;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      peak_q <= {SAMPLE_W{1'b0}};
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak_o = peak_q;
`endif

endmodule

// File: tb/tb_poly_voice_mixer.sv
// Randomised self-checking bench for poly_voice_mixer against an arithmetic
// reference (sum of active voices, floor-divided by their count).
module tb_poly_voice_mixer;
  localparam int NV = 4;
  localparam int SW = 9;
  localparam int DIVLAT = 12;

  logic              clk;
  logic              n_rst;
  logic              start_i;
  logic [NV*SW-1:0]  sample_i;
  logic [NV-1:0]     active_i;
  logic [SW-1:0]     mix_o;
  logic              ready_o;
  logic              busy_o;
  logic              overrun_o;
`ifdef MIX_PEAK_EN
  logic              peak_clr_i;
  logic [SW-1:0]     peak_o;
`endif

  int total = 0;
  int bad   = 0;
  int peak_exp = 0;

  poly_voice_mixer #(.NUM_VOICES(NV), .SAMPLE_W(SW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start_i   (start_i),
    .sample_i  (sample_i),
    .active_i  (active_i),
`ifdef MIX_PEAK_EN
    .peak_clr_i(peak_clr_i),
    .peak_o    (peak_o),
`endif
    .mix_o     (mix_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o),
    .overrun_o (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NV*SW-1:0] pack(input int v0, input int v1, input int v2, input int v3);
    logic [NV*SW-1:0] p;
    p = '0;
    p[0*SW +: SW] = SW'(v0);
    p[1*SW +: SW] = SW'(v1);
    p[2*SW +: SW] = SW'(v2);
    p[3*SW +: SW] = SW'(v3);
    return p;
  endfunction

  // One operation: start at edge 0, optional extra start at edge ovr_at (0 = none).
  task automatic do_op(input logic [NV*SW-1:0] smp, input logic [NV-1:0] msk,
                       input int ovr_at, input logic clr);
    int sum, cnt, exp_mix, lat, got_edge;
    sum = 0;
    cnt = 0;
    for (int k = 0; k < NV; k++) begin
      if (msk[k]) begin
        sum += int'(smp[k*SW +: SW]);
        cnt++;
      end
    end
    exp_mix = (cnt == 0) ? 0 : sum / cnt;
    lat = NV + ((cnt >= 2) ? DIVLAT : 1);

    @(negedge clk);
    start_i  = 1'b1;
    sample_i = smp;
    active_i = msk;
`ifdef MIX_PEAK_EN
    peak_clr_i = clr;
`endif
    @(posedge clk);
    #1;
    start_i  = 1'b0;
    sample_i = {$urandom, $urandom};
    active_i = NV'($urandom);
    got_edge = 0;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      start_i = (e == ovr_at);
      if (e == ovr_at) begin
        sample_i = {$urandom, $urandom};
        active_i = NV'($urandom);
      end
      @(posedge clk);
      #1;
      if (e == 1) check_eq("busy_run", int'(busy_o), 1);
      if (e == ovr_at) check_eq("overrun_hi", int'(overrun_o), 1);
      else check_eq("overrun_lo", int'(overrun_o), 0);
      if (ready_o) begin
        got_edge = e;
        break;
      end
    end
    check_eq("latency", got_edge, lat);
    check_eq("mix", int'(mix_o), exp_mix);
    if (clr) peak_exp = 0;
    else if (exp_mix > peak_exp) peak_exp = exp_mix;
`ifdef MIX_PEAK_EN
    check_eq("peak", int'(peak_o), peak_exp);
`endif
    @(negedge clk);
    start_i = 1'b0;
`ifdef MIX_PEAK_EN
    peak_clr_i = 1'b0;
`endif
    @(posedge clk);
    #1;
    check_eq("ready_single", int'(ready_o), 0);
    check_eq("busy_idle", int'(busy_o), 0);
    check_eq("mix_hold", int'(mix_o), exp_mix);
  endtask

  initial begin
    logic [NV*SW-1:0] rs;
    logic [NV-1:0]    rm;
    int               ro;
    n_rst    = 1'b0;
    start_i  = 1'b0;
    sample_i = '0;
    active_i = '0;
`ifdef MIX_PEAK_EN
    peak_clr_i = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mix", int'(mix_o), 0);
    check_eq("rst_ready", int'(ready_o), 0);
    check_eq("rst_busy", int'(busy_o), 0);
    check_eq("rst_overrun", int'(overrun_o), 0);
    @(negedge clk);
    n_rst = 1'b1;

    do_op(pack(100, 200, 300, 400), 4'b1111, 0, 1'b0);
    do_op(pack(511, 300, 7, 300), 4'b0101, 0, 1'b0);
    do_op(pack(7, 8, 100, 100), 4'b0011, 0, 1'b0);
    do_op(pack(1, 300, 2, 3), 4'b0010, 0, 1'b0);
    do_op(pack(400, 400, 400, 400), 4'b0000, 0, 1'b0);
    do_op(pack(100, 200, 300, 400), 4'b1111, 3, 1'b0);
    do_op(pack(100, 100, 100, 100), 4'b1111, 0, 1'b0);
    do_op(pack(50, 60, 70, 80), 4'b1110, 0, 1'b1);

    // Asynchronous reset in the middle of the division.
    do_op(pack(500, 500, 500, 500), 4'b1111, 0, 1'b0);
    @(negedge clk);
    start_i  = 1'b1;
    sample_i = pack(10, 20, 30, 40);
    active_i = 4'b1111;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    check_eq("mid_rst_mix", int'(mix_o), 0);
    check_eq("mid_rst_ready", int'(ready_o), 0);
    check_eq("mid_rst_busy", int'(busy_o), 0);
    peak_exp = 0;
`ifdef MIX_PEAK_EN
    check_eq("mid_rst_peak", int'(peak_o), 0);
`endif
    @(negedge clk);
    n_rst = 1'b1;
    do_op(pack(11, 22, 33, 44), 4'b1011, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rs = {$urandom, $urandom};
      rm = NV'($urandom);
      ro = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
      do_op(rs, rm, ro, ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
